// File: rtl/sobel_edge_binariser_pkg.sv
// ---------------------------------------------------------------------------
// sobel_edge_binariser_pkg
//
// Shared definitions for the Sobel edge binariser slice: the frame FSM state
// encoding, the image/word geometry and a small popcount helper used by the
// byte thresholding stage.
//
// Contents:
//   state_t      - frame FSM states (IDLE, RUN, FLUSH, DONE)
//   IMG_PIXELS   - pixels per frame (512 x 512)
//   WORD_PIX     - magnitude pixels per input SRAM word
//   BITMAP_PIX   - bitmap pixels per output SRAM word
//   GROUPS       - input words that make up one bitmap word
//   GROUP_W      - width of the group field inside an input address
//   popcount8    - number of set bits in an 8-bit mask
// ---------------------------------------------------------------------------
package sobel_edge_binariser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int IMG_PIXELS = 262144;
  localparam int WORD_PIX   = 8;
  localparam int BITMAP_PIX = 64;
  localparam int GROUPS     = BITMAP_PIX / WORD_PIX;
  localparam int GROUP_W    = $clog2(GROUPS);

  // Counts the edge bits of one thresholded input word (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] bits);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sobel_edge_binariser_if.sv
// ---------------------------------------------------------------------------
// sobel_edge_binariser_if
//
// Bundles the two SRAM write streams seen by the binariser: the magnitude
// write stream coming from the Sobel output stage and the bitmap write
// stream going to the edge-bitmap SRAM.
//
// Signals:
//   we_in, addr_in, data_in    - magnitude word write (8 pixels per word)
//   we_out, addr_out, data_out - bitmap word write (64 pixels per word)
//
// Modports:
//   master - upstream/environment side: drives the magnitude stream and
//            observes the bitmap stream
//   slave  - binariser side: consumes the magnitude stream and drives the
//            bitmap stream
// ---------------------------------------------------------------------------
interface sobel_edge_binariser_if
  import sobel_edge_binariser_pkg::*;
#(
  parameter int ADDR_W = 20
);

  logic                    we_in;
  logic [ADDR_W-1:0]       addr_in;
  logic [WORD_PIX*8-1:0]   data_in;

  logic                    we_out;
  logic [ADDR_W-1:0]       addr_out;
  logic [BITMAP_PIX-1:0]   data_out;

  modport master (
    output we_in,
    output addr_in,
    output data_in,
    input  we_out,
    input  addr_out,
    input  data_out
  );

  modport slave (
    input  we_in,
    input  addr_in,
    input  data_in,
    output we_out,
    output addr_out,
    output data_out
  );

endinterface

// File: rtl/sobel_byte_threshold.sv
// ---------------------------------------------------------------------------
// sobel_byte_threshold
//
// Purely combinational: compares each of the 8 magnitude lanes of an input
// word against the threshold and returns one edge bit per lane plus the
// number of edge bits in the word.
//
// Ports:
//   data      in   8 lanes of PIX_W-bit magnitudes, lane k at [PIX_W*k +: PIX_W]
//   threshold in   magnitude threshold
//   mask      out  bit k = lane k strictly greater than threshold (unsigned)
//   count     out  popcount of mask (0..8)
// ---------------------------------------------------------------------------
module sobel_byte_threshold
  import sobel_edge_binariser_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [WORD_PIX*PIX_W-1:0] data,
  input  logic [PIX_W-1:0]          threshold,
  output logic [WORD_PIX-1:0]       mask,
  output logic [3:0]                count
);

  // A pixel is an edge only when its magnitude is strictly above the
  // threshold, so a magnitude equal to the threshold yields 0.
  always_comb begin
    mask = '0;
    for (int k = 0; k < WORD_PIX; k++) begin
      mask[k] = (data[k*PIX_W +: PIX_W] > threshold);
    end
  end

  assign count = popcount8(mask);

endmodule

// File: rtl/sobel_edge_binariser.sv
// ---------------------------------------------------------------------------
// sobel_edge_binariser
//
// Sits on the Sobel magnitude SRAM write stream. Each accepted input word
// (8 magnitude pixels) is thresholded into one byte of a 64-pixel bitmap
// word. Completed bitmap words are written to the bitmap SRAM, the number of
// edge pixels in the frame is counted, and frameDone pulses once the frame
// has been flushed.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   startEn    in   pulse: start (or restart) a frame, samples threshold
//   frameEnd   in   pulse: flush the pending bitmap word and end the frame
//   threshold  in   magnitude threshold
//   bus        slave modport: magnitude stream in, bitmap stream out
//   edgeCount  out  edge pixels seen in the current frame (saturating)
//   frameDone  out  one-cycle pulse when the frame is complete
//   busy       out  high while the FSM is in RUN or FLUSH
// ---------------------------------------------------------------------------
module sobel_edge_binariser
  import sobel_edge_binariser_pkg::*;
#(
  parameter int                ADDR_W   = 20,
  parameter int                PIX_W    = 8,
  parameter logic [ADDR_W-1:0] OUT_BASE = '0,
  parameter int                CNT_W    = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      startEn,
  input  logic                      frameEnd,
  input  logic [7:0]                threshold,
  sobel_edge_binariser_if.slave     bus,
  output logic [CNT_W-1:0]          edgeCount,
  output logic                      frameDone,
  output logic                      busy
);

  localparam int IDX_W  = ADDR_W - GROUP_W;
  localparam int N_CAND = 4;

  state_t                state;
  state_t                state_next;

  logic [7:0]            thr_reg;
  logic [BITMAP_PIX-1:0] pending;
  logic                  pend_valid;
  logic [IDX_W-1:0]      pend_idx;

  logic                  skid_valid;
  logic [IDX_W-1:0]      skid_idx;
  logic [BITMAP_PIX-1:0] skid_data;

  logic [IDX_W-1:0]      idx_in;
  logic [GROUP_W-1:0]    grp_in;
  logic [WORD_PIX-1:0]   mask;
  logic [3:0]            mask_count;

  logic                  start_take;
  logic                  accept;
  logic                  index_change;
  logic                  group_done;
  logic                  flush_take;
  logic [BITMAP_PIX-1:0] merged;
  logic [CNT_W:0]        count_sum;

  logic [N_CAND-1:0]     cand_valid;
  logic [IDX_W-1:0]      cand_idx  [N_CAND];
  logic [BITMAP_PIX-1:0] cand_data [N_CAND];

  logic                  wr_valid;
  logic [IDX_W-1:0]      wr_idx;
  logic [BITMAP_PIX-1:0] wr_data;
  logic                  skid_valid_next;
  logic [IDX_W-1:0]      skid_idx_next;
  logic [BITMAP_PIX-1:0] skid_data_next;

  sobel_byte_threshold #(
    .PIX_W (PIX_W)
  ) u_threshold (
    .data      (bus.data_in),
    .threshold (thr_reg),
    .mask      (mask),
    .count     (mask_count)
  );

  // Input address split: upper bits select the bitmap word, the low three
  // bits select which byte of that word this input word fills. startEn takes
  // priority over a same-cycle input word so a restart never mixes frames.
  assign idx_in       = bus.addr_in[ADDR_W-1:GROUP_W];
  assign grp_in       = bus.addr_in[GROUP_W-1:0];
  assign start_take   = startEn && ((state == IDLE) || (state == RUN));
  assign accept       = (state == RUN) && bus.we_in && !startEn;
  assign index_change = pend_valid && (pend_idx != idx_in);
  assign group_done   = (grp_in == GROUP_W'(GROUPS - 1));
  assign flush_take   = (state == FLUSH) && pend_valid;
  assign count_sum    = {1'b0, edgeCount} + {{(CNT_W - 3){1'b0}}, mask_count};

  // Builds the bitmap word that results from accepting the current input.
  // A word for a different index starts from zero, so bytes of the new word
  // that never arrive read back as 0 when it is eventually written.
  always_comb begin
    merged = (pend_valid && !index_change) ? pending : '0;
    merged[{grp_in, 3'b000} +: WORD_PIX] = mask;
  end

  // Collects every word that wants to be written this cycle, oldest first:
  // the skid entry from last cycle, the displaced pending word, the word just
  // completed by group 7, and the word flushed at frame end. The first goes
  // to the output register and the next one waits in the skid register.
  // The skid entry is only ever filled when no word stays pending, so the
  // following cycle can add at most one more candidate and nothing is lost.
  always_comb begin
    cand_valid[0] = skid_valid;
    cand_idx[0]   = skid_idx;
    cand_data[0]  = skid_data;
    cand_valid[1] = accept && index_change;
    cand_idx[1]   = pend_idx;
    cand_data[1]  = pending;
    cand_valid[2] = accept && group_done;
    cand_idx[2]   = idx_in;
    cand_data[2]  = merged;
    cand_valid[3] = flush_take;
    cand_idx[3]   = pend_idx;
    cand_data[3]  = pending;

    wr_valid        = 1'b0;
    wr_idx          = '0;
    wr_data         = '0;
    skid_valid_next = 1'b0;
    skid_idx_next   = '0;
    skid_data_next  = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (cand_valid[i]) begin
        if (!wr_valid) begin
          wr_valid = 1'b1;
          wr_idx   = cand_idx[i];
          wr_data  = cand_data[i];
        end else begin
          skid_valid_next = 1'b1;
          skid_idx_next   = cand_idx[i];
          skid_data_next  = cand_data[i];
        end
      end
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame FSM next-state logic. FLUSH and DONE each last exactly one cycle;
  // a startEn during RUN simply stays in RUN with the frame restarted.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (startEn) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (startEn) begin
          state_next = RUN;
        end else if (frameEnd) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so that busy lines up
  // with the RUN/FLUSH cycles and frameDone lines up with the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      busy      <= (state_next == RUN) || (state_next == FLUSH);
      frameDone <= (state_next == DONE);
    end
  end

  // Frame datapath: threshold latch, pending bitmap word and edge counter.
  // A start clears everything, which also discards a half-built word
  // without writing it. Once a word is emitted nothing stays pending unless
  // the same input started a new word.
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_reg    <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      edgeCount  <= '0;
    end else if (start_take) begin
      thr_reg    <= threshold;
      pending    <= '0;
      pend_valid <= 1'b0;
      edgeCount  <= '0;
    end else if (accept) begin
      edgeCount <= count_sum[CNT_W] ? '1 : count_sum[CNT_W-1:0];
      pend_idx  <= idx_in;
      if (group_done) begin
        pending    <= '0;
        pend_valid <= 1'b0;
      end else begin
        pending    <= merged;
        pend_valid <= 1'b1;
      end
    end else if (flush_take) begin
      pending    <= '0;
      pend_valid <= 1'b0;
    end
  end

  // Bitmap write port and its one-entry skid. The skid keeps draining in
  // every state so a word queued on the last accepted input still goes out
  // after the frame has moved on. addr_out/data_out hold their last value
  // between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.we_out   <= 1'b0;
      bus.addr_out <= '0;
      bus.data_out <= '0;
      skid_valid   <= 1'b0;
      skid_idx     <= '0;
      skid_data    <= '0;
    end else begin
      bus.we_out <= wr_valid;
      if (wr_valid) begin
        bus.addr_out <= OUT_BASE + {{GROUP_W{1'b0}}, wr_idx};
        bus.data_out <= wr_data;
      end
      skid_valid <= skid_valid_next;
      skid_idx   <= skid_idx_next;
      skid_data  <= skid_data_next;
    end
  end

endmodule

// File: tb/tb_sobel_edge_binariser.sv
// ---------------------------------------------------------------------------
// tb_sobel_edge_binariser
//
// Drives frames of magnitude words into sobel_edge_binariser and compares
// the bitmap writes, edge counts and frame flags against a frame-level model
// of the thresholding and packing rules.
// ---------------------------------------------------------------------------
module tb_sobel_edge_binariser;
  import sobel_edge_binariser_pkg::*;

  localparam int                ADDR_W   = 20;
  localparam int                CNT_W    = 20;
  localparam logic [ADDR_W-1:0] OUT_BASE = '0;
  localparam logic [63:0]       ALL_FF   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             reset;
  logic             startEn;
  logic             frameEnd;
  logic [7:0]       threshold;
  logic [CNT_W-1:0] edgeCount;
  logic             frameDone;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drive_cyc = 0;

  logic [ADDR_W-1:0] got_addr [$];
  logic [63:0]       got_data [$];
  int                got_cyc  [$];
  int                done_cyc [$];
  logic [ADDR_W-1:0] exp_addr [$];
  logic [63:0]       exp_data [$];

  int          m_thr;
  int          m_idx;
  int          m_count;
  logic        m_valid;
  logic [63:0] m_word;

  sobel_edge_binariser_if #(.ADDR_W(ADDR_W)) bus ();

  sobel_edge_binariser #(
    .ADDR_W   (ADDR_W),
    .PIX_W    (8),
    .OUT_BASE (OUT_BASE),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .startEn   (startEn),
    .frameEnd  (frameEnd),
    .threshold (threshold),
    .bus       (bus),
    .edgeCount (edgeCount),
    .frameDone (frameDone),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cycle counter: cycle N starts at the Nth rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Records every bitmap write and every frameDone pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.we_out === 1'b1) begin
      got_addr.push_back(bus.addr_out);
      got_data.push_back(bus.data_out);
      got_cyc.push_back(cyc);
    end
    if (frameDone === 1'b1) begin
      done_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Applies one cycle of inputs, set just after a rising edge.
  task automatic applyStimulus(input logic we, input int addr, input logic [63:0] data,
                               input logic st, input logic fe, input logic [7:0] thr);
    @(posedge clk);
    #1;
    bus.we_in   = we;
    bus.addr_in = ADDR_W'(addr);
    bus.data_in = data;
    startEn     = st;
    frameEnd    = fe;
    threshold   = thr;
    drive_cyc   = cyc;
  endtask

  function automatic logic [7:0] edgeByte(input logic [63:0] d, input int thr);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin
      b[k] = (int'(d[8*k +: 8]) > thr);
    end
    return b;
  endfunction

  function automatic int firstInt(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  task automatic expectWrite(input int idx, input logic [63:0] word);
    exp_addr.push_back(OUT_BASE + ADDR_W'(idx));
    exp_data.push_back(word);
  endtask

  task automatic modelClear();
    m_valid = 1'b0;
    m_word  = '0;
    m_idx   = 0;
  endtask

  // Frame-level model: bitmap word = 8 thresholded bytes; a word is written
  // when its byte 7 arrives, when another word's byte arrives, or at frame end.
  task automatic modelWord(input int addr, input logic [63:0] data);
    int idx;
    int grp;
    logic [7:0] bits;
    idx  = addr / 8;
    grp  = addr % 8;
    bits = edgeByte(data, m_thr);
    for (int k = 0; k < 8; k++) m_count += int'(bits[k]);
    if (m_count > (1 << CNT_W) - 1) m_count = (1 << CNT_W) - 1;
    if (m_valid && idx != m_idx) begin
      expectWrite(m_idx, m_word);
      modelClear();
    end
    m_word[8*grp +: 8] = bits;
    m_idx   = idx;
    m_valid = 1'b1;
    if (grp == 7) begin
      expectWrite(m_idx, m_word);
      modelClear();
    end
  endtask

  task automatic modelFlush();
    if (m_valid) expectWrite(m_idx, m_word);
    modelClear();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, '0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic doStart(input int thr);
    applyStimulus(1'b0, 0, '0, 1'b1, 1'b0, 8'(thr));
    m_thr   = thr;
    m_count = 0;
    modelClear();
  endtask

  task automatic doWord(input int addr, input logic [63:0] data);
    applyStimulus(1'b1, addr, data, 1'b0, 1'b0, 8'd0);
    modelWord(addr, data);
  endtask

  task automatic doWordEnd(input int addr, input logic [63:0] data);
    applyStimulus(1'b1, addr, data, 1'b0, 1'b1, 8'd0);
    modelWord(addr, data);
    modelFlush();
  endtask

  task automatic doEnd();
    applyStimulus(1'b0, 0, '0, 1'b0, 1'b1, 8'd0);
    modelFlush();
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset       = 1'b1;
    bus.we_in   = 1'b0;
    startEn     = 1'b0;
    frameEnd    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    m_thr   = 0;
    m_count = 0;
    modelClear();
  endtask

  task automatic compareWrites(input string tag);
    int n;
    checkOutput({tag, " writes"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s addr[%0d]", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
      checkOutput($sformatf("%s data[%0d]", tag, i), got_data[i], exp_data[i]);
    end
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  initial begin
    int fe;
    int t;
    logic [63:0] d;

    reset       = 1'b1;
    startEn     = 1'b0;
    frameEnd    = 1'b0;
    threshold   = 8'd0;
    bus.we_in   = 1'b0;
    bus.addr_in = '0;
    bus.data_in = '0;
    doReset();

    checkOutput("rst we_out", 64'(bus.we_out), 64'd0);
    checkOutput("rst addr_out", 64'(bus.addr_out), 64'd0);
    checkOutput("rst data_out", bus.data_out, 64'd0);
    checkOutput("rst edgeCount", 64'(edgeCount), 64'd0);
    checkOutput("rst frameDone", 64'(frameDone), 64'd0);
    checkOutput("rst busy", 64'(busy), 64'd0);

    // Full bitmap word of edges, written one cycle after its 8th byte.
    $display("[TB] full word of 0xFF lanes");
    doStart(100);
    for (int a = 0; a < 8; a++) doWord(a, ALL_FF);
    t = drive_cyc;
    idle(3);
    checkOutput("full count", 64'(edgeCount), 64'd64);
    checkOutput("full busy", 64'(busy), 64'd1);
    checkOutput("full addr", 64'(got_addr.size() > 0 ? got_addr[0] : 'x), 64'd0);
    checkOutput("full data", got_data.size() > 0 ? got_data[0] : 'x, ALL_FF);
    checkOutput("full wcyc", 64'(firstInt(got_cyc)), 64'(t + 1));
    compareWrites("full");
    doEnd();
    fe = drive_cyc;
    idle(4);
    checkOutput("full done cyc", 64'(firstInt(done_cyc)), 64'(fe + 2));
    checkOutput("full busy end", 64'(busy), 64'd0);
    checkOutput("full count hold", 64'(edgeCount), 64'd64);
    compareWrites("full end");
    done_cyc.delete();

    // Strict compare: equal to threshold is not an edge, one above is.
    $display("[TB] threshold boundary");
    doStart(100);
    for (int a = 0; a < 8; a++) doWord(a, {8{8'd100}});
    idle(2);
    checkOutput("eq count", 64'(edgeCount), 64'd0);
    for (int a = 8; a < 16; a++) doWord(a, {8{8'd101}});
    idle(3);
    checkOutput("gt count", 64'(edgeCount), 64'd64);
    checkOutput("eq data", got_data.size() > 0 ? got_data[0] : 'x, 64'd0);
    checkOutput("gt data", got_data.size() > 1 ? got_data[1] : 'x, ALL_FF);
    compareWrites("boundary");
    doEnd();
    idle(4);
    done_cyc.delete();

    // Partial word flushed at frame end with missing bytes zero.
    $display("[TB] partial word flush");
    doStart(100);
    doWord(8, ALL_FF);
    doWord(9, ALL_FF);
    doWord(10, ALL_FF);
    doEnd();
    fe = drive_cyc;
    idle(4);
    checkOutput("flush addr", 64'(got_addr.size() > 0 ? got_addr[0] : 'x), 64'd1);
    checkOutput("flush data", got_data.size() > 0 ? got_data[0] : 'x, 64'h0000_0000_00FF_FFFF);
    checkOutput("flush wcyc", 64'(firstInt(got_cyc)), 64'(fe + 2));
    checkOutput("flush done cyc", 64'(firstInt(done_cyc)), 64'(fe + 2));
    compareWrites("flush");
    done_cyc.delete();

    // Index change plus group 7: two writes on consecutive cycles.
    $display("[TB] index change with group 7");
    doStart(100);
    doWord(3, ALL_FF);
    doWord(15, ALL_FF);
    t = drive_cyc;
    idle(4);
    checkOutput("skid data0", got_data.size() > 0 ? got_data[0] : 'x, 64'h0000_0000_FF00_0000);
    checkOutput("skid cyc0", 64'(firstInt(got_cyc)), 64'(t + 1));
    checkOutput("skid addr1", 64'(got_addr.size() > 1 ? got_addr[1] : 'x), 64'd1);
    checkOutput("skid data1", got_data.size() > 1 ? got_data[1] : 'x, 64'hFF00_0000_0000_0000);
    checkOutput("skid cyc1", 64'(got_cyc.size() > 1 ? got_cyc[1] : -1), 64'(t + 2));
    compareWrites("skid");
    doEnd();
    idle(4);
    done_cyc.delete();

    // Reset mid-frame discards the pending word; frameEnd in IDLE is ignored.
    $display("[TB] reset mid-frame");
    doStart(100);
    for (int a = 0; a < 5; a++) doWord(a, ALL_FF);
    doReset();
    idle(3);
    checkOutput("midrst writes", 64'(got_addr.size()), 64'd0);
    checkOutput("midrst addr_out", 64'(bus.addr_out), 64'd0);
    checkOutput("midrst data_out", bus.data_out, 64'd0);
    checkOutput("midrst count", 64'(edgeCount), 64'd0);
    checkOutput("midrst busy", 64'(busy), 64'd0);
    doEnd();
    idle(4);
    checkOutput("idle frameEnd done", 64'(done_cyc.size()), 64'd0);
    compareWrites("midrst");
    done_cyc.delete();

    // Restart inside RUN: pending bytes dropped, new threshold applies.
    $display("[TB] restart in RUN");
    doStart(100);
    for (int a = 0; a < 4; a++) doWord(a, {8{8'd200}});
    doStart(200);
    idle(2);
    checkOutput("restart count", 64'(edgeCount), 64'd0);
    checkOutput("restart writes", 64'(got_addr.size()), 64'd0);
    for (int k = 0; k < 8; k++) d[8*k +: 8] = (k % 2 == 1) ? 8'd201 : 8'd200;
    for (int a = 0; a < 8; a++) doWord(a, d);
    idle(3);
    checkOutput("restart count2", 64'(edgeCount), 64'd32);
    checkOutput("restart data", got_data.size() > 0 ? got_data[0] : 'x, 64'hAAAA_AAAA_AAAA_AAAA);
    compareWrites("restart");
    doEnd();
    idle(4);
    done_cyc.delete();

    // Randomised frames against the model.
    $display("[TB] random frames");
    for (int f = 0; f < 12; f++) begin
      int n_words;
      int a;
      int prev;
      int thr;
      thr = $urandom_range(0, 255);
      doStart(thr);
      prev    = -1;
      n_words = $urandom_range(1, 30);
      for (int w = 0; w < n_words; w++) begin
        if (prev >= 0 && $urandom_range(0, 2) == 0) a = (prev + 1) % 32;
        else a = $urandom_range(0, 31);
        prev = a;
        for (int k = 0; k < 8; k++) begin
          case ($urandom_range(0, 2))
            0: d[8*k +: 8] = 8'($urandom_range(0, 255));
            1: d[8*k +: 8] = 8'(m_thr);
            default: d[8*k +: 8] = (m_thr == 255) ? 8'd255 : 8'(m_thr + 1);
          endcase
        end
        if (w == n_words - 1 && $urandom_range(0, 1) == 1) begin
          doWordEnd(a, d);
        end else begin
          doWord(a, d);
          if (w == n_words - 1) doEnd();
        end
        if (w != n_words - 1) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          if ($urandom_range(0, 39) == 0) doStart($urandom_range(0, 255));
        end
      end
      idle(5);
      compareWrites($sformatf("rnd%0d", f));
      checkOutput($sformatf("rnd%0d count", f), 64'(edgeCount), 64'(m_count));
      checkOutput($sformatf("rnd%0d done", f), 64'(done_cyc.size()), 64'd1);
      checkOutput($sformatf("rnd%0d busy", f), 64'(busy), 64'd0);
      done_cyc.delete();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_edge_binariser.md
Name: sobel_edge_binariser

Overview:
- Sits directly downstream of the Sobel magnitude output stage and consumes its SRAM write stream (64-bit data, write enable, 20-bit address), where each word holds 8 magnitude pixels.
- Thresholds each pixel and packs the results 64 pixels per word into a 1-bit edge bitmap, which it writes to a bitmap SRAM port.
- Keeps a per-frame edge-pixel count and pulses a done flag for the particle detection control logic.

Parameters:
- ADDR_W, 20: width of the input and output SRAM addresses.
- PIX_W, 8: pixel width; must equal 8 because the input is 8 lanes of 64 bits.
- OUT_BASE, 20'd0: base address added to the bitmap word index.
- CNT_W, 20: width of the edge counter (holds up to 262144 pixels).

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high reset.
- startEn, in, 1: one-cycle pulse that starts a frame.
- frameEnd, in, 1: one-cycle pulse that flushes the pending word and ends the frame.
- threshold, in, 8: magnitude threshold, sampled when startEn is accepted.
- we_in, in, 1: input write strobe from the magnitude stage.
- addr_in, in, ADDR_W: input word address; each word holds 8 pixels.
- data_in, in, 64: 8 magnitudes; lane k is data_in[8k+7:8k] and is pixel 8*addr_in+k.
- we_out, out, 1: bitmap write strobe.
- addr_out, out, ADDR_W: bitmap word address.
- data_out, out, 64: bitmap word; bit b is pixel 64*(addr_out-OUT_BASE)+b.
- edgeCount, out, CNT_W: number of edge pixels seen in the current frame.
- frameDone, out, 1: one-cycle pulse when the frame is complete.
- busy, out, 1: high in RUN and FLUSH.

Behaviour:
- Reset, and the registered values every output holds after it:
  - we_out = 0, addr_out = 0, data_out = 0, edgeCount = 0, frameDone = 0, busy = 0.
  - FSM = IDLE, pending word cleared, pending-valid = 0, threshold register = 0.
  - Reset wins over every other input in the same cycle. Reset mid-frame discards the pending word and produces no write.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: startEn moves to RUN; it latches threshold and clears edgeCount, the pending word and pending-valid. we_in is ignored in IDLE.
  - RUN: accepts input words (rules below). frameEnd moves to FLUSH. startEn in RUN restarts the frame: the pending word is discarded with no write, the counter clears and the threshold is re-latched.
  - FLUSH (1 cycle): if pending-valid, write the pending word on the next cycle with missing bits 0. Then move to DONE.
  - DONE (1 cycle): frameDone = 1, then move to IDLE.
- Per-pixel rule: bit = (lane > threshold_reg), a strict compare, unsigned.
- Input word acceptance in RUN:
  - The bitmap index is addr_in[ADDR_W-1:3] and the group is addr_in[2:0].
  - The 8 result bits go into pending[8*group+7 : 8*group]. A later write to the same group overwrites those bits.
  - edgeCount adds the popcount (0..8) of the new byte.
- Index change: if pending-valid and the incoming index differs from the pending index, first emit the old pending word (missing bits 0), then start a new pending word with the incoming byte. Both happen in the same cycle.
- Emission: when group 7 is accepted, the completed word (including the group-7 byte) is written.
- Write timing: we_out = 1 on the cycle after the triggering input, for exactly one cycle. addr_out = OUT_BASE + index. At most one write per cycle.
- Group 7 while a different index is pending: the old word is flushed and the new single-group word is also complete. The old word is written in cycle t+1 and the new one in t+2, using a one-entry skid register.
- After any emission, pending-valid = 0 unless a new word started.
- we_in and frameEnd in the same cycle: the word is accepted first, and FLUSH includes it.
- FLUSH with no pending word produces no write.
- edgeCount holds its value through DONE and IDLE until the next startEn. It cannot overflow for 2^18 pixels; it saturates at all-ones regardless.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=0, RUN=1, FLUSH=2, DONE=3).
  - IMG_PIXELS = 262144, WORD_PIX = 8, BITMAP_PIX = 64.
- Sub-module: sobel_byte_threshold, combinational. It takes 64-bit data and an 8-bit threshold, and returns the 8-bit mask and a 4-bit popcount.

Test Plan:
- Reset, startEn with threshold = 100, then 8 words at addr 0..7, all lanes 0xFF → one write at addr_out 0, data_out = all ones, one cycle after the addr-7 input; edgeCount = 64.
- Lanes = 100 with threshold 100 → all bits 0, edgeCount = 0. Lanes = 101 → all bits 1.
- Words at addr 8, 9, 10 only, all lanes 0xFF, then frameEnd → one write at addr_out 1, data_out = 0x0000000000FFFFFF; frameDone pulses 2 cycles after frameEnd.
- addr 3 (lanes 0xFF) followed next cycle by addr 15 (lanes 0xFF) → write at addr 0 = 0x00000000FF000000 at t+1, then write at addr 1 = 0xFF00000000000000 at t+2.
- Reset asserted after 5 words of a frame → no write, all outputs 0. Then frameEnd in IDLE → no frameDone.
- startEn in RUN with 4 words pending → no write, edgeCount = 0, new threshold used for the following words.
